// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source (solid / colour bars / checkerboard / grey ramp) on an AXI4-Stream.
// Define VGA_PATTERN_SCROLL_EN to scroll patterns 1-3 left by one pixel per frame.
module vga_pattern_gen #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int CHECKER_LOG2 = 5
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            enable,
    input  logic [1:0]      pattern_sel,
    input  logic [2:0][3:0] solid_color,
    output logic            pix_tvalid,
    input  logic            pix_tready,
    output logic [2:0][3:0] pix_tdata,
    output logic            pix_tlast,
    output logic            pix_tuser,
    output logic            busy
);
    localparam int X_W    = ($clog2(H_RES) > CHECKER_LOG2) ? $clog2(H_RES) : CHECKER_LOG2 + 1;
    localparam int Y_W    = ($clog2(V_RES) > CHECKER_LOG2) ? $clog2(V_RES) : CHECKER_LOG2 + 1;
    localparam int BAR_W  = H_RES / 8;
    localparam int RAMP_W = H_RES / 16;
    localparam int BC_W   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int RC_W   = (RAMP_W > 1) ? $clog2(RAMP_W) : 1;

    localparam logic [X_W-1:0]  X_LAST  = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_RES - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BAR_W - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RAMP_W - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]      state_q, state_d;
    logic            vld_q, vld_d;
    logic [2:0][3:0] dat_q, dat_d;
    logic            last_q, last_d;
    logic            user_q, user_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [X_W-1:0]  xe_q, xe_d;
    logic [2:0]      bseg_q, bseg_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic [3:0]      gseg_q, gseg_d;
    logic [RC_W-1:0] gcnt_q, gcnt_d;
    logic [1:0]      pat_q, pat_d;
    logic [2:0][3:0] solid_q, solid_d;

    // x_eff and segment-counter values that every line starts from
    logic [X_W-1:0]  ls_xe;
    logic [2:0]      ls_bseg;
    logic [BC_W-1:0] ls_bcnt;
    logic [3:0]      ls_gseg;
    logic [RC_W-1:0] ls_gcnt;

    logic hs, at_x_last, at_y_last, frame_done, load;

    assign hs         = vld_q && pix_tready;
    assign at_x_last  = (x_q == X_LAST);
    assign at_y_last  = (y_q == Y_LAST);
    assign frame_done = hs && at_x_last && at_y_last;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [X_W-1:0]  fc_q, fc_d;
    logic [2:0]      fbseg_q, fbseg_d;
    logic [BC_W-1:0] fbcnt_q, fbcnt_d;
    logic [3:0]      fgseg_q, fgseg_d;
    logic [RC_W-1:0] fgcnt_q, fgcnt_d;

    // Frame counter carries its own segment position so lines can start mid-segment
    always_comb begin
        fc_d    = fc_q;
        fbseg_d = fbseg_q;
        fbcnt_d = fbcnt_q;
        fgseg_d = fgseg_q;
        fgcnt_d = fgcnt_q;
        if (frame_done) begin
            fc_d = (fc_q == X_LAST) ? '0 : fc_q + 1'b1;
            if (fbcnt_q == BC_LAST) begin
                fbcnt_d = '0;
                fbseg_d = fbseg_q + 3'd1;
            end else begin
                fbcnt_d = fbcnt_q + 1'b1;
            end
            if (fgcnt_q == RC_LAST) begin
                fgcnt_d = '0;
                fgseg_d = fgseg_q + 4'd1;
            end else begin
                fgcnt_d = fgcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fc_q    <= '0;
            fbseg_q <= '0;
            fbcnt_q <= '0;
            fgseg_q <= '0;
            fgcnt_q <= '0;
        end else begin
            fc_q    <= fc_d;
            fbseg_q <= fbseg_d;
            fbcnt_q <= fbcnt_d;
            fgseg_q <= fgseg_d;
            fgcnt_q <= fgcnt_d;
        end
    end

    assign ls_xe   = fc_d;
    assign ls_bseg = fbseg_d;
    assign ls_bcnt = fbcnt_d;
    assign ls_gseg = fgseg_d;
    assign ls_gcnt = fgcnt_d;
`else
    assign ls_xe   = '0;
    assign ls_bseg = '0;
    assign ls_bcnt = '0;
    assign ls_gseg = '0;
    assign ls_gcnt = '0;
`endif

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        dat_d   = dat_q;
        last_d  = last_q;
        user_d  = user_q;
        x_d     = x_q;
        y_d     = y_q;
        xe_d    = xe_q;
        bseg_d  = bseg_q;
        bcnt_d  = bcnt_q;
        gseg_d  = gseg_q;
        gcnt_d  = gcnt_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        load    = 1'b0;

        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_ACTIVE;
                vld_d   = 1'b1;
                load    = 1'b1;
                x_d     = '0;
                y_d     = '0;
                xe_d    = ls_xe;
                bseg_d  = ls_bseg;
                bcnt_d  = ls_bcnt;
                gseg_d  = ls_gseg;
                gcnt_d  = ls_gcnt;
            end
        end else if (hs) begin
            load = 1'b1;
            if (at_x_last) begin
                x_d    = '0;
                xe_d   = ls_xe;
                bseg_d = ls_bseg;
                bcnt_d = ls_bcnt;
                gseg_d = ls_gseg;
                gcnt_d = ls_gcnt;
                if (at_y_last) begin
                    y_d = '0;
                    if (!enable) begin
                        state_d = S_IDLE;
                        vld_d   = 1'b0;
                        load    = 1'b0;
                    end
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d  = x_q + 1'b1;
                xe_d = (xe_q == X_LAST) ? '0 : xe_q + 1'b1;
                if (bcnt_q == BC_LAST) begin
                    bcnt_d = '0;
                    bseg_d = bseg_q + 3'd1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
                if (gcnt_q == RC_LAST) begin
                    gcnt_d = '0;
                    gseg_d = gseg_q + 4'd1;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
        end

        if (load) begin
            user_d = (x_d == '0) && (y_d == '0);
            last_d = (x_d == X_LAST);
            if (user_d) begin
                pat_d   = pattern_sel;
                solid_d = solid_color;
            end
            // Bar order white..black maps to b=~seg[0], g=~seg[2], r=~seg[1]
            case (pat_d)
                2'd0:    dat_d = solid_d;
                2'd1:    dat_d = {{4{~bseg_d[0]}}, {4{~bseg_d[2]}}, {4{~bseg_d[1]}}};
                2'd2:    dat_d = (xe_d[CHECKER_LOG2] ^ y_d[CHECKER_LOG2]) ? 12'h000 : 12'hFFF;
                default: dat_d = {gseg_d, gseg_d, gseg_d};
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            xe_q    <= '0;
            bseg_q  <= '0;
            bcnt_q  <= '0;
            gseg_q  <= '0;
            gcnt_q  <= '0;
            pat_q   <= '0;
            solid_q <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            last_q  <= last_d;
            user_q  <= user_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xe_q    <= xe_d;
            bseg_q  <= bseg_d;
            bcnt_q  <= bcnt_d;
            gseg_q  <= gseg_d;
            gcnt_q  <= gcnt_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
        end
    end

    assign pix_tvalid = vld_q;
    assign pix_tdata  = dat_q;
    assign pix_tlast  = last_q;
    assign pix_tuser  = user_q;
    assign busy       = (state_q == S_ACTIVE);

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter H_RES, default 640, active pixels per line (multiple of 16).
REQ-002 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-003 SHALL have parameter CHECKER_LOG2, default 5, log2 of checker cell size in pixels.
REQ-004 SHALL have port aclk  input  1  single clock for all logic.
REQ-005 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  run request; level-sensitive.
REQ-007 SHALL have port pattern_sel  input  2  0 solid, 1 colour bars, 2 checkerboard, 3 grey ramp.
REQ-008 SHALL have port solid_color  input  [2:0][3:0]  {b,g,r} for pattern 0.
REQ-009 SHALL have port pix_tvalid  output  1  AXI4-Stream valid to downstream VGA timing stage.
REQ-010 SHALL have port pix_tready  input  1  AXI4-Stream ready.
REQ-011 SHALL have port pix_tdata  output  [2:0][3:0]  pixel {b,g,r}.
REQ-012 SHALL have port pix_tlast  output  1  last pixel of line (x = H_RES-1).
REQ-013 SHALL have port pix_tuser  output  1  first pixel of frame (x = 0, y = 0).
REQ-014 SHALL have port busy  output  1  high while FSM is in ACTIVE.

Function
REQ-015 SHALL implement FSM states IDLE and ACTIVE; IDLE->ACTIVE when enable=1; ACTIVE->IDLE only after handshake of pixel (H_RES-1, V_RES-1) with enable=0 at that cycle.
REQ-016 SHALL, on IDLE->ACTIVE, assert pix_tvalid the cycle after enable is sampled high, presenting pixel (0,0) with pix_tuser=1.
REQ-017 SHALL keep pix_tdata, pix_tlast, pix_tuser stable and pix_tvalid high while pix_tvalid=1 and pix_tready=0.
REQ-018 SHALL advance to the next pixel only on handshake (pix_tvalid and pix_tready both 1); output registered, next pixel presented the following cycle, allowing one pixel per cycle sustained.
REQ-019 SHALL count x 0..H_RES-1 and y 0..V_RES-1; x wraps to 0 and y increments after tlast handshake; y wraps to 0 after last pixel of frame.
REQ-020 SHALL keep pix_tvalid high across frame boundaries with no gap while enable=1.
REQ-021 SHALL sample pattern_sel and solid_color only when presenting pixel (0,0); changes mid-frame take effect at the next frame.
REQ-022 SHALL, for pattern 1, output 8 bars of width H_RES/8 in order white, yellow, cyan, green, magenta, red, blue, black (components 4'hF or 4'h0), via a segment counter, no divider.
REQ-023 SHALL, for pattern 2, output white (12'hFFF) when x[CHECKER_LOG2] XOR y[CHECKER_LOG2] = 0, else black.
REQ-024 SHALL, for pattern 3, output r=g=b=k for segment k = 0..15, segment width H_RES/16.
REQ-025 SHALL, when enable drops mid-frame, finish the current frame, then deassert pix_tvalid and return to IDLE.
REQ-026 SHALL hold pix_tvalid=0 in IDLE.

Reset
REQ-027 SHALL, on aresetn=0, asynchronously clear pix_tvalid, pix_tdata, pix_tlast, pix_tuser, busy, x, y, segment counters and frame counter, and enter IDLE.
REQ-028 SHALL, after reset mid-frame, restart at pixel (0,0) with pix_tuser=1.

Configuration
REQ-029 SHALL, with macro VGA_PATTERN_SCROLL_EN defined, keep a frame counter 0..H_RES-1 that increments after each frame's last handshake and wraps to 0, and compute patterns 1-3 from x_eff = (x + frame counter) mod H_RES.
REQ-030 SHALL, without VGA_PATTERN_SCROLL_EN, use x_eff = x and implement no frame counter.

Verification
REQ-031 SHALL verify: reset, enable=1, pix_tready=1 -> first valid pixel cycle after enable; tuser=1 only at (0,0); tlast every 640th beat; 307200 beats per frame.
REQ-032 SHALL verify: pattern_sel=1, tready=1 -> beats 0..79 = 12'hFFF, beats 80..159 = {b=0,g=F,r=F}, beats 560..639 = 12'h000.
REQ-033 SHALL verify: random tready backpressure -> data/tuser/tlast stable during stall; frame content identical to no-stall run.
REQ-034 SHALL verify: pattern_sel changed 0->2 at line 100 -> current frame stays solid, next frame checkerboard (pixel (32,0) = 12'h000).
REQ-035 SHALL verify: enable=0 at line 200 -> frame completes with last beat (639,479), then tvalid=0 and busy=0; aresetn pulse mid-frame -> restart at (0,0).
REQ-036 SHALL verify with VGA_PATTERN_SCROLL_EN: pattern 1, second frame pixel (0,0) equals first frame pixel (1,0).
